// File: rtl/spi_block_sequencer.sv
// spi_block_sequencer
//   Moves a block of bytes between the on-chip buffer and the single-byte SPI
//   engine so the CPU does not have to poll every byte. It also shares the
//   buffer port with the cartridge-bus reader, which always has priority.
//
//   Optional build macro: SPI_BLOCK_SEQ_CRC16_EN adds a CRC16-CCITT
//   (poly 0x1021, init 0, MSB first) over the completed bytes. Without the
//   macro, Crc is tied to zero.
//
// Ports
//   FastClk, nReset           clock, asynchronous active-low reset
//   Start, Abort, Mode,       transfer control (Mode: 0 TX, 1 RX, 2 XCHG, 3 = RX)
//   Length                    Length is the byte count minus one
//   Busy, Done, Count         status; Count = bytes completed
//   ByteStart, ByteTx,        byte-engine handshake
//   ByteBusy, ByteRx
//   BufAddr, BufWrData,       buffer port (1-cycle read latency)
//   BufWe, BufRdData
//   CartReq, CartAddr,        cartridge read requests; the cart always wins
//   CartGrant
//   Crc                       CRC of the last transfer
module spi_block_sequencer #(
  parameter int unsigned ADDR_W    = 9,
  parameter logic [7:0]  FILL_BYTE = 8'hFF
) (
  input  logic              FastClk,
  input  logic              nReset,
  input  logic              Start,
  input  logic              Abort,
  input  logic [1:0]        Mode,
  input  logic [ADDR_W-1:0] Length,
  output logic              Busy,
  output logic              Done,
  output logic [ADDR_W:0]   Count,
  output logic              ByteStart,
  output logic [7:0]        ByteTx,
  input  logic              ByteBusy,
  input  logic [7:0]        ByteRx,
  output logic [ADDR_W-1:0] BufAddr,
  output logic [7:0]        BufWrData,
  output logic              BufWe,
  input  logic [7:0]        BufRdData,
  input  logic              CartReq,
  input  logic [ADDR_W-1:0] CartAddr,
  output logic              CartGrant,
  output logic [15:0]       Crc
);

  localparam int unsigned CW = ADDR_W + 1;

  typedef enum logic [2:0] {
    StIdle, StFetch, StFetchWait, StSend, StWait, StStore, StNext, StDone
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [7:0]        tx_q, tx_d;
  logic [7:0]        rx_q, rx_d;
  logic              seen_q, seen_d;    // ByteBusy has been seen high for this byte
  logic              abort_q, abort_d;  // Abort is latched until the next byte boundary

  logic              mode_fetch;

  // TX and XCHG read the buffer. RX and the reserved mode send FILL_BYTE.
  assign mode_fetch = (mode_q == 2'd0) || (mode_q == 2'd2);

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    len_d     = len_q;
    count_d   = count_q;
    ptr_d     = ptr_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    seen_d    = seen_q;
    abort_d   = abort_q | Abort;
    ByteStart = 1'b0;
    BufWe     = 1'b0;
    unique case (state_q)
      StIdle: begin
        abort_d = 1'b0;
        if (Start) begin
          mode_d  = Mode;
          len_d   = Length;
          count_d = '0;
          ptr_d   = '0;
          abort_d = Abort;
          if ((Mode == 2'd0) || (Mode == 2'd2)) begin
            state_d = StFetch;
          end else begin
            tx_d    = FILL_BYTE;
            state_d = StSend;
          end
        end
      end
      StFetch: begin
        if (!CartReq) state_d = StFetchWait;
      end
      StFetchWait: begin
        // The read was issued last cycle without cart interference.
        tx_d    = BufRdData;
        state_d = StSend;
      end
      StSend: begin
        ByteStart = 1'b1;
        seen_d    = 1'b0;
        state_d   = StWait;
      end
      StWait: begin
        if (ByteBusy) begin
          seen_d = 1'b1;
        end else if (seen_q) begin
          rx_d = ByteRx;
          if (mode_q == 2'd0) begin
            count_d = count_q + CW'(1);
            ptr_d   = ptr_q + 1'b1;
            state_d = StNext;
          end else begin
            state_d = StStore;
          end
        end
      end
      StStore: begin
        if (!CartReq) begin
          BufWe   = 1'b1;
          count_d = count_q + CW'(1);
          ptr_d   = ptr_q + 1'b1;
          state_d = StNext;
        end
      end
      StNext: begin
        if ((count_q == ({1'b0, len_q} + CW'(1))) || abort_q || Abort) begin
          state_d = StDone;
        end else if (mode_fetch) begin
          state_d = StFetch;
        end else begin
          state_d = StSend;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge FastClk or negedge nReset) begin
    if (!nReset) begin
      state_q <= StIdle;
      mode_q  <= 2'd0;
      len_q   <= '0;
      count_q <= '0;
      ptr_q   <= '0;
      tx_q    <= 8'h00;
      rx_q    <= 8'h00;
      seen_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      len_q   <= len_d;
      count_q <= count_d;
      ptr_q   <= ptr_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      seen_q  <= seen_d;
      abort_q <= abort_d;
    end
  end

  assign Busy      = (state_q != StIdle) && (state_q != StDone);
  assign Done      = (state_q == StDone);
  assign Count     = count_q;
  assign ByteTx    = tx_q;
  assign CartGrant = CartReq;
  assign BufAddr   = CartReq ? CartAddr : ptr_q;
  assign BufWrData = rx_q;

`ifdef SPI_BLOCK_SEQ_CRC16_EN
  function automatic logic [15:0] crc16_upd(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    for (int i = 0; i < 8; i++) begin
      r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    end
    return r;
  endfunction

  logic [15:0] crc_q, crc_d;
  logic        crc_en;
  logic [7:0]  crc_byte;

  // A byte completes when TX leaves WAIT, or when RX/XCHG commits its store.
  assign crc_en   = ((state_q == StWait) && !ByteBusy && seen_q && (mode_q == 2'd0)) ||
                    ((state_q == StStore) && !CartReq);
  assign crc_byte = (state_q == StStore) ? rx_q : tx_q;

  always_comb begin
    crc_d = crc_q;
    if ((state_q == StIdle) && Start) begin
      crc_d = 16'h0000;
    end else if (crc_en) begin
      crc_d = crc16_upd(crc_q, crc_byte);
    end
  end

  always_ff @(posedge FastClk or negedge nReset) begin
    if (!nReset) crc_q <= 16'h0000;
    else         crc_q <= crc_d;
  end

  assign Crc = crc_q;
`else
  assign Crc = 16'h0000;
`endif

endmodule

// File: doc/spi_block_sequencer.md
Name: spi_block_sequencer

Overview:
- Sequences multi-byte SD/flash SPI transfers between an on-chip byte buffer (blockram port) and the single-byte SPI engine.
- Frees the WonderSwan CPU from per-byte polling of SPI_DATA/SPI_CNT.
- Arbitrates the buffer port between the cartridge-bus reader (priority) and the sequencer.
- Runs in the FastClk domain; the start/length/mode registers come from the I/O register decoder, already synchronised to FastClk.

Parameters:
- ADDR_W, 9: buffer address width; buffer holds 2^ADDR_W bytes (512).
- FILL_BYTE, 8'hFF: transmit byte in RX mode.

Ports:
- FastClk, in, 1: sole clock.
- nReset, in, 1: asynchronous, active-low reset.
- Start, in, 1: one-cycle pulse, begin transfer; ignored while Busy.
- Abort, in, 1: level; terminates transfer at next byte boundary.
- Mode, in, 2: 0 TX (buffer->SPI, rx discarded), 1 RX (FILL_BYTE->SPI, rx->buffer), 2 XCHG (buffer->SPI, rx overwrites same address), 3 reserved (treated as RX).
- Length, in, ADDR_W: byte count minus one (0 = 1 byte, all-ones = 2^ADDR_W bytes).
- Busy, out, 1: transfer in progress.
- Done, out, 1: one-cycle pulse on completion or abort.
- Count, out, ADDR_W+1: bytes completed in current/last transfer.
- ByteStart, out, 1: one-cycle pulse to SPI engine.
- ByteTx, out, 8: byte to send, held stable from ByteStart until ByteBusy falls.
- ByteBusy, in, 1: engine busy; rises the cycle after ByteStart, falls when ByteRx is valid.
- ByteRx, in, 8: received byte.
- BufAddr, out, ADDR_W: buffer address; muxed to CartAddr when CartGrant=1.
- BufWrData, out, 8: buffer write data.
- BufWe, out, 1: buffer write strobe; never asserted while CartGrant=1.
- BufRdData, in, 8: buffer read data, 1-cycle latency after address.
- CartReq, in, 1: cartridge bus requests buffer read.
- CartAddr, in, ADDR_W: cartridge read address.
- CartGrant, out, 1: cart owns buffer port this cycle.
- Crc, out, 16: CRC result (see Optional Feature).

Behaviour:
- Reset: state IDLE; Busy=0, Done=0, Count=0, ByteStart=0, ByteTx=8'h00, BufAddr=0, BufWe=0, CartGrant=0, Crc=0. Reset mid-transfer drops everything immediately; the engine byte in flight is abandoned.
- Arbitration: CartGrant = CartReq combinationally, every state. Cart always wins. The sequencer stalls in FETCH/STORE while CartReq=1 and holds its internal pointer.

States:
- IDLE: on Start, latch Mode and Length, clear Count and Ptr, set Busy; go to FETCH if Mode is TX/XCHG, else to SEND with ByteTx=FILL_BYTE.
- FETCH: drive BufAddr=Ptr for a cycle without CartReq, then wait 1 cycle; capture BufRdData into ByteTx; go to SEND.
- SEND: pulse ByteStart for 1 cycle; go to WAIT.
- WAIT: wait for ByteBusy falling (seen high, then low). Then go to STORE if Mode is RX/XCHG; otherwise Count++, Ptr++ and go to NEXT.
- STORE: when CartReq=0, assert BufWe for 1 cycle with BufAddr=Ptr and BufWrData=ByteRx; Count++, Ptr++; go to NEXT.
- NEXT: if Count == Length+1 or Abort, go to DONE; else go to FETCH or SEND according to Mode.
- DONE: pulse Done, clear Busy, go to IDLE. Count holds its final value until the next Start.

Rules:
- Per-byte overhead is at most 4 FastClk cycles plus cart stalls.
- Ptr wraps modulo 2^ADDR_W; wrap is only reachable for a full-length transfer.
- Start while Busy: ignored.
- Start and Abort in the same cycle in IDLE: transfer starts, completes 1 byte, then ends.
- Abort never cuts a byte in flight; the current byte completes and is stored.
- ByteTx changes only in IDLE or FETCH.

Optional Feature:
- Macro SPI_BLOCK_SEQ_CRC16_EN.
- Defined: CRC16-CCITT (poly 0x1021, init 0x0000, MSB first), cleared on Start.
  - Updated over transmitted bytes in TX mode and received bytes in RX/XCHG modes, one byte per completed byte.
  - Crc is valid when Done pulses and is held until the next Start.
- Undefined: Crc tied to 16'h0000; no CRC logic synthesised.

Test Plan:
- Reset: hold nReset=0 with Start=1 -> all outputs at reset values. Release -> IDLE, Busy=0.
- TX: buffer[0..3]=11,22,33,44; Mode=0, Length=3, Start -> 4 ByteStart pulses with ByteTx 11,22,33,44; BufWe never high; Done once; Count=4.
- RX: Mode=1, Length=1; engine returns A5,5A -> ByteTx=FF both bytes; buffer[0]=A5, buffer[1]=5A; Count=2.
- Cart contention: XCHG, Length=0; CartReq=1 across FETCH and STORE -> CartGrant=1, no BufWe while granted; stall then resumes; buffer[0]=ByteRx.
- Abort: Mode=0, Length=511; assert Abort during byte 5 -> byte 5 completes; Done; Count=6; Busy=0. Start while Busy is ignored.
- CRC (macro on): RX of 512 bytes all FF -> Crc=16'h7FA1. Macro off -> Crc=0.
